barrel_unshifter: RTL and testbench
===================================

Name: barrel_unshifter

Overview:
Streaming inverse of the team's N-bit barrel shifter. It takes a word that was produced by a shift or rotate, together with the original mode and shift amount, and applies the inverse operation. It also flags words whose zero-filled bits are non-zero, which proves the word was not produced by that operation. The block sits on the receive side of the datapath, behind a 2-stage valid/ready pipeline with full backpressure.

Parameters:
N, 4, data width; must be a power of 2 and at least 2.
SW, $clog2(N), shift-amount width; derived, not overridden.
ERR_CNT_W, 8, width of the saturating error counter (optional feature only).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset; asynchronous assert, active-low.
in_valid  input  1  input word present.
in_ready  output  1  block accepts the input this cycle.
in_data  input  N  shifted or rotated word.
in_shift  input  SW  shift amount originally applied.
in_mode  input  2  original mode: 00 shl, 01 shr, 10 rotl, 11 rotr.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts the result.
out_data  output  N  recovered word.
out_err  output  1  consistency error for this word.
err_count  output  ERR_CNT_W  saturating count of words with out_err set (optional feature).

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_data, in_shift and in_mode are sampled only on an input transfer.
- Pipeline stages:
  - S1 registers the inputs with valid bit s1_v.
  - S2 registers the result (out_data, out_err) with out_valid.
  - Latency is 2 cycles from input transfer to out_valid when no stall occurs.
  - Throughput is 1 word per cycle.
- Stall logic:
  - s2_load = !out_valid || out_ready.
  - in_ready = !s1_v || s2_load; it is combinational from out_ready, with no dependence on in_valid.
  - S1 advances into S2 when s1_v && s2_load.
  - When s1_v is set and s2_load is false, S1 holds.
- Order: no word is dropped or duplicated; order is preserved.
- Inverse map (computed from S1 contents):
  - mode 00: out = d >> s.
  - mode 01: out = d << s.
  - mode 10: out = rotr(d, s).
  - mode 11: out = rotl(d, s).
  - Rotates with s = 0 pass d through unchanged. There is no N-shift term when s = 0.
- Error rules:
  - mode 00: err = |(d & ((1<<s)-1)), i.e. any of the low s bits is set.
  - mode 01: err = |(d & ~({N{1}} >> s)), i.e. any of the high s bits is set.
  - Rotates: err = 0.
  - s = 0: err = 0 in every mode.
  - On error, out_data is still the computed inverse.
- Width rules:
  - All shifts are N-bit logical with zero fill.
  - s ranges over 0..N-1; no wider intermediate result is kept.
- Reset (asynchronous, rst_n = 0):
  - s1_v = 0, out_valid = 0, out_data = 0, out_err = 0, err_count = 0.
  - in_ready is 1 while in reset and on the first cycle after release.
  - Any in-flight words are discarded.
- Boundary conditions:
  - Both stages full and out_ready = 0: in_ready = 0 and all state holds.
  - Both stages full and out_ready = 1: simultaneous output transfer, S1-to-S2 move, and new input accept, all in the same cycle.
  - Data registers do not change while their valid bit is 1 and the stage is stalled.

Optional Feature:
BARREL_UNSHIFTER_ERRCNT_EN.
- Defined: err_count increments by 1 on each output transfer with out_err = 1. It saturates at all-ones and never wraps.
- Not defined: the err_count port still exists and is tied to 0; no counter flops are built.

Decomposition:
- Shared package barrel_pkg:
  - mode constants MODE_SHL = 2'b00, MODE_SHR = 2'b01, MODE_ROTL = 2'b10, MODE_ROTR = 2'b11.
  - The mode is a 2-bit typedef, so the forward shifter and this block use identical encodings.
- One natural sub-module, barrel_unshift_core:
  - purely combinational; inputs (d, s, mode), outputs (out, err); instantiated between S1 and S2.
  - It is verified standalone against the forward shifter: forward-then-inverse of any rotate must return the original word.

Test Plan:
- N=4, mode=10, s=1, d=0110 -> out_data=0011, out_err=0 two cycles later. mode=11, s=1, d=1001 -> out_data=0011, out_err=0.
- mode=00, s=2: d=1100 -> out_data=0011, err=0; d=1101 -> out_data=0011, err=1. mode=01, s=1, d=1011 -> out_data=0110, err=1.
- s=0 in all four modes with d=1010 -> out_data=1010, err=0.
- Backpressure: offer 3 back-to-back words with out_ready=0 -> 2 accepted, then in_ready=0. Raise out_ready -> 3 outputs in order, with no gaps once flowing.
- Deassert rst_n with both stages full -> out_valid=0 and in_ready=1 immediately. After release, the next accepted word emerges with correct latency and err_count=0.
- With BARREL_UNSHIFTER_ERRCNT_EN, ERR_CNT_W=2: 5 erroring transfers -> err_count=3, held. Without the macro, err_count stays 0.

Source files
------------

// File: rtl/barrel_pkg.sv
// -----------------------------------------------------------------------------
// barrel_pkg
// Definitions shared by the forward barrel shifter and barrel_unshifter.
// Both blocks import this package, so they use the same mode encoding.
//
// Contents:
//   mode_t            2-bit shift/rotate mode
//   MODE_SHL/SHR/ROTL/ROTR
//                     mode encodings (00 shl, 01 shr, 10 rotl, 11 rotr)
//   mode_is_rotate()  1 for the two rotate modes
// -----------------------------------------------------------------------------
package barrel_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SHL  = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_ROTL = 2'b10;
  localparam mode_t MODE_ROTR = 2'b11;

  // Rotates lose no bits, so they can never be flagged as inconsistent.
  function automatic logic mode_is_rotate(input mode_t m);
    return m[1];
  endfunction

endpackage

// File: rtl/barrel_unshift_core.sv
// -----------------------------------------------------------------------------
// barrel_unshift_core
// Purely combinational inverse of the N-bit barrel shifter.
// out is the inverse of the original operation:
//   shl -> shr
//   shr -> shl
//   rotl -> rotr
//   rotr -> rotl
// err is set when a bit that the forward shift would have zero-filled is 1.
//
// Parameters:
//   N   data width (power of 2, >= 2)
//   SW  shift-amount width, $clog2(N)
// Ports:
//   d     input  [N-1:0]   shifted/rotated word
//   s     input  [SW-1:0]  original shift amount
//   mode  input  mode_t    original mode
//   out   output [N-1:0]   recovered word
//   err   output           consistency error
// -----------------------------------------------------------------------------
module barrel_unshift_core
  import barrel_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  d,
  input  logic [SW-1:0] s,
  input  mode_t         mode,
  output logic [N-1:0]  out,
  output logic          err
);

  logic [N-1:0]   ones_s;
  logic [N-1:0]   shr_s;
  logic [N-1:0]   shl_s;
  logic [N-1:0]   low_mask_s;
  logic [N-1:0]   high_mask_s;
  logic [2*N-1:0] dd_s;
  logic [2*N-1:0] rotr_wide_s;
  logic [2*N-1:0] rotl_wide_s;
  logic [N-1:0]   rotr_s;
  logic [N-1:0]   rotl_s;

  assign ones_s = {N{1'b1}};
  assign shr_s  = d >> s;
  assign shl_s  = d << s;

  // Masks of the bit positions the forward shift would have zero-filled.
  // With s = 0 both masks are empty, so err is 0.
  assign low_mask_s  = ~(ones_s << s);
  assign high_mask_s = ~(ones_s >> s);

  // Shifting a doubled word and taking one half gives the rotate without
  // any N-s shift term, so s = 0 passes d through unchanged.
  assign dd_s        = {d, d};
  assign rotr_wide_s = dd_s >> s;
  assign rotl_wide_s = dd_s << s;
  assign rotr_s      = rotr_wide_s[N-1:0];
  assign rotl_s      = rotl_wide_s[2*N-1:N];

  // Select the inverse operation and its error check from the original mode.
  always_comb begin
    out = {N{1'b0}};
    err = 1'b0;
    case (mode)
      MODE_SHL: begin
        out = shr_s;
        err = |(d & low_mask_s);
      end
      MODE_SHR: begin
        out = shl_s;
        err = |(d & high_mask_s);
      end
      MODE_ROTL: begin
        out = rotr_s;
        err = 1'b0;
      end
      MODE_ROTR: begin
        out = rotl_s;
        err = 1'b0;
      end
      default: begin
        out = {N{1'b0}};
        err = 1'b0;
      end
    endcase
    if (mode_is_rotate(mode)) begin
      err = 1'b0;
    end else begin
      err = err;
    end
  end

endmodule

// File: rtl/barrel_unshifter.sv
// -----------------------------------------------------------------------------
// barrel_unshifter
// Streaming inverse of the N-bit barrel shifter.
// Two-stage valid/ready pipeline with full backpressure:
//   S1 registers the input word, shift amount and mode.
//   S2 registers the recovered word and its consistency error.
// Latency is 2 cycles and throughput is 1 word per cycle.
//
// Optional feature (compile-time macro): BARREL_UNSHIFTER_ERRCNT_EN
//   Defined     : err_count is a saturating count of output transfers
//                 with out_err = 1.
//   Not defined : err_count is tied to 0 and no counter flops are built.
//
// Parameters:
//   N          data width (power of 2, >= 2)
//   SW         shift-amount width, derived as $clog2(N)
//   ERR_CNT_W  error counter width
// Ports:
//   clk        input                 rising-edge clock
//   rst_n      input                 async active-low reset
//   in_valid   input                 input word present
//   in_ready   output                input accepted this cycle
//   in_data    input  [N-1:0]        shifted/rotated word
//   in_shift   input  [SW-1:0]       original shift amount
//   in_mode    input  [1:0]          original mode
//   out_valid  output                result present
//   out_ready  input                 downstream accepts result
//   out_data   output [N-1:0]        recovered word
//   out_err    output                consistency error for out_data
//   err_count  output [ERR_CNT_W-1:0] saturating error count
// -----------------------------------------------------------------------------
module barrel_unshifter
  import barrel_pkg::*;
#(
  parameter int N         = 4,
  parameter int SW        = $clog2(N),
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [SW-1:0]        in_shift,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic          s1_v_r;
  logic [N-1:0]  s1_data_r;
  logic [SW-1:0] s1_shift_r;
  mode_t         s1_mode_r;

  logic          out_valid_r;
  logic [N-1:0]  out_data_r;
  logic          out_err_r;

  logic          s2_load_s;
  logic          in_fire_s;
  logic          out_fire_s;
  logic [N-1:0]  core_out_s;
  logic          core_err_s;

  // S2 can take a word when it is empty or its word leaves this cycle.
  // in_ready depends only on state and out_ready, never on in_valid.
  assign s2_load_s  = !out_valid_r || out_ready;
  assign in_ready   = !s1_v_r || s2_load_s;
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid_r && out_ready;

  // S1 register: load on an input transfer, clear when the word moves on,
  // hold while S2 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_r     <= 1'b0;
      s1_data_r  <= {N{1'b0}};
      s1_shift_r <= {SW{1'b0}};
      s1_mode_r  <= MODE_SHL;
    end else if (in_fire_s) begin
      s1_v_r     <= 1'b1;
      s1_data_r  <= in_data;
      s1_shift_r <= in_shift;
      s1_mode_r  <= mode_t'(in_mode);
    end else if (s2_load_s) begin
      s1_v_r     <= 1'b0;
    end else begin
      s1_v_r     <= s1_v_r;
    end
  end

  barrel_unshift_core #(
    .N  (N),
    .SW (SW)
  ) u_core (
    .d    (s1_data_r),
    .s    (s1_shift_r),
    .mode (s1_mode_r),
    .out  (core_out_s),
    .err  (core_err_s)
  );

  // S2 register: capture the inverse result when S2 can load, else hold.
  // The data registers change only when a new word actually arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {N{1'b0}};
      out_err_r   <= 1'b0;
    end else if (s2_load_s) begin
      out_valid_r <= s1_v_r;
      if (s1_v_r) begin
        out_data_r <= core_out_s;
        out_err_r  <= core_err_s;
      end else begin
        out_data_r <= out_data_r;
        out_err_r  <= out_err_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;

`ifdef BARREL_UNSHIFTER_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_count_r;

  // Saturating count of erroring words as they leave the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= {ERR_CNT_W{1'b0}};
    end else if (out_fire_s && out_err_r && (err_count_r != {ERR_CNT_W{1'b1}})) begin
      err_count_r <= err_count_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`else
  logic unused_fire_s;
  assign unused_fire_s = out_fire_s;
  assign err_count     = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_barrel_unshifter.sv
// Directed self-checking bench for barrel_unshifter (N = 4).
module tb_barrel_unshifter;

`ifdef BARREL_UNSHIFTER_ERRCNT_EN
  localparam int ERRW = 2;
`else
  localparam int ERRW = 8;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_data;
  logic [1:0]      in_shift;
  logic [1:0]      in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_data;
  logic            out_err;
  logic [ERRW-1:0] err_count;

  int n_assert;
  int n_fail;

  barrel_unshifter #(.N(4), .ERR_CNT_W(ERRW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One word with out_ready=1; result checked two cycles after acceptance.
  task automatic word(input string tag, input logic [3:0] d, input logic [1:0] s,
                      input logic [1:0] m, input logic [3:0] eo, input logic ee);
    in_valid = 1'b1; in_data = d; in_shift = s; in_mode = m; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(eo));
    chk({tag, "_err"},   32'(out_err),   32'(ee));
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; in_shift = 2'd0;
    in_mode = 2'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Main function, hand-computed vectors.
    word("rotl_s1",  4'b0110, 2'd1, 2'b10, 4'b0011, 1'b0);
    word("rotr_s1",  4'b1001, 2'd1, 2'b11, 4'b0011, 1'b0);
    word("shl_ok",   4'b1100, 2'd2, 2'b00, 4'b0011, 1'b0);
    word("shl_err",  4'b1101, 2'd2, 2'b00, 4'b0011, 1'b1);
    word("shr_err",  4'b1011, 2'd1, 2'b01, 4'b0110, 1'b1);
    word("s0_shl",   4'b1010, 2'd0, 2'b00, 4'b1010, 1'b0);
    word("s0_shr",   4'b1010, 2'd0, 2'b01, 4'b1010, 1'b0);
    word("s0_rotl",  4'b1010, 2'd0, 2'b10, 4'b1010, 1'b0);
    word("s0_rotr",  4'b1010, 2'd0, 2'b11, 4'b1010, 1'b0);
    word("shr_s3",   4'b0001, 2'd3, 2'b01, 4'b1000, 1'b0);
    word("shl_s3",   4'b1000, 2'd3, 2'b00, 4'b0001, 1'b0);
    word("rotl_s3",  4'b0001, 2'd3, 2'b10, 4'b0010, 1'b0);
    word("shr_s3e",  4'b1000, 2'd3, 2'b01, 4'b0000, 1'b1);
    @(posedge clk); #1;
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: A, B, C offered with out_ready=0.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'b0010; in_shift = 2'd1; in_mode = 2'b00;  // A -> 0001
    chk("bp_ready_a", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_ready_b", 32'(in_ready), 32'd1);
    in_data = 4'b0100;                                                     // B -> 0010
    @(posedge clk); #1;
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_a_valid", 32'(out_valid), 32'd1);
    chk("bp_a_data",  32'(out_data),  32'd1);
    in_data = 4'b0110;                                                     // C -> 0011
    @(posedge clk); #1;
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_data",  32'(out_data), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_b_valid", 32'(out_valid), 32'd1);
    chk("bp_b_data",  32'(out_data),  32'd2);
    @(posedge clk); #1;
    chk("bp_c_valid", 32'(out_valid), 32'd1);
    chk("bp_c_data",  32'(out_data),  32'd3);
    @(posedge clk); #1;
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'b1101; in_shift = 2'd2; in_mode = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rf_full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rf_out_valid", 32'(out_valid), 32'd0);
    chk("rf_in_ready",  32'(in_ready),  32'd1);
    chk("rf_out_err",   32'(out_err),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rf_rel_valid", 32'(out_valid), 32'd0);
    word("rf_after", 4'b0110, 2'd1, 2'b10, 4'b0011, 1'b0);
    chk("rf_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;

    // Error counter: 5 erroring words (shl s=1, d=0001 -> 0000, err).
    for (int i = 0; i < 5; i++) begin
      word("cnt_word", 4'b0001, 2'd1, 2'b00, 4'b0000, 1'b1);
      if (i == 2) begin
`ifdef BARREL_UNSHIFTER_ERRCNT_EN
        chk("cnt_mid", 32'(err_count), 32'd2);
`else
        chk("cnt_mid", 32'(err_count), 32'd0);
`endif
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("cnt_drained", 32'(out_valid), 32'd0);
`ifdef BARREL_UNSHIFTER_ERRCNT_EN
    chk("cnt_sat", 32'(err_count), 32'd3);
`else
    chk("cnt_tied", 32'(err_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
